pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RV32I pipeline; merges hazard_unit and forwarding_unit.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select codes, controller FSM states and default widths.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int LU_W       = 2;  // holds LOAD_USE_CYC-1 for LOAD_USE_CYC up to 3

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_D_WAIT   = 2'b10
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority match of one ID-stage source register against the EX/MEM/WB
// producers; reports per-stage hits and the EX>MEM>WB forward choice.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output fwd_e              sel,
  output logic              ex_hit,
  output logic              mem_hit,
  output logic              wb_hit
);

  logic live;

  // x0 is hardwired zero, so it never creates a dependency.
  assign live    = rs_used && (rs != '0);
  assign ex_hit  = live && ex_we  && (ex_rd  == rs);
  assign mem_hit = live && mem_we && (mem_rd == rs);
  assign wb_hit  = live && wb_we  && (wb_rd  == rs);

  // A load in EX has no data yet; it is covered by the load-use stall instead.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !ex_load) sel = FWD_EX;
    else if (mem_hit)       sel = FWD_MEM;
    else if (wb_hit)        sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: stage
// enables, bubbles, flushes, ID forward selects and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = DEF_REG_AW,
  parameter int LOAD_USE_CYC = 1,
  parameter int FWD_EN       = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_redirect,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              wb_we,
  input  logic              ex_load,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_bubble,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_src1,
  output logic [1:0]        fwd_src2,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_e            state_q, state_d, prior_q, prior_d, eff_state;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  fwd_e              sel1, sel2;
  logic              ex_hit1, mem_hit1, wb_hit1, ex_hit2, mem_hit2, wb_hit2;
  logic              d_stall, lu_detect, any_hit, hz_stall;

  fwd_select #(.REG_AW(REG_AW)) u_fwd1 (
    .rs(id_rs1), .rs_used(id_use1), .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
    .sel(sel1), .ex_hit(ex_hit1), .mem_hit(mem_hit1), .wb_hit(wb_hit1)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd2 (
    .rs(id_rs2), .rs_used(id_use2), .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
    .sel(sel2), .ex_hit(ex_hit2), .mem_hit(mem_hit2), .wb_hit(wb_hit2)
  );

  assign d_stall   = dmem_req && !dmem_ready;
  assign lu_detect = ex_load && (ex_hit1 || ex_hit2);
  assign any_hit   = ex_hit1 || mem_hit1 || wb_hit1 || ex_hit2 || mem_hit2 || wb_hit2;
  // D_WAIT is a freeze: once memory answers, the frozen state resumes that cycle.
  assign eff_state = (state_q == ST_D_WAIT) ? prior_q : state_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    prior_d      = prior_q;
    lu_cnt_d     = lu_cnt_q;
    hz_stall     = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_bubble = 1'b0;
    id_ex_bubble = 1'b0;
    fwd_src1     = (FWD_EN != 0) ? sel1 : FWD_RF;
    fwd_src2     = (FWD_EN != 0) ? sel2 : FWD_RF;

    if (rst) begin
      fwd_src1 = FWD_RF;
      fwd_src2 = FWD_RF;
    end else if (d_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = ST_D_WAIT;
      prior_d   = eff_state;
    end else begin
      state_d = ST_RUN;
      if (FWD_EN == 0) begin
        hz_stall = any_hit;
      end else if (eff_state == ST_LU_STALL) begin
        hz_stall = 1'b1;
        lu_cnt_d = lu_cnt_q - 1'b1;
        if (lu_cnt_d != '0) state_d = ST_LU_STALL;
      end else if (lu_detect) begin
        // The detect cycle is the first bubble; LU_STALL supplies the rest.
        hz_stall = 1'b1;
        if (LOAD_USE_CYC > 1) begin
          state_d  = ST_LU_STALL;
          lu_cnt_d = LU_W'(LOAD_USE_CYC - 1);
        end
      end

      if (hz_stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end else begin
        pc_en        = imem_ready || id_redirect;
        if_id_bubble = !imem_ready || id_redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      prior_q      <= ST_RUN;
      lu_cnt_q     <= '0;
      stall_cycles <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      prior_q  <= prior_d;
      lu_cnt_q <= lu_cnt_d;
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: three controller configurations driven in parallel,
// directed scenarios followed by random stimulus against a bubble-count model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use1, id_use2, id_redirect, ex_we, mem_we, wb_we, ex_load;
  logic       imem_ready, dmem_req, dmem_ready;

  logic       pc_en[3], if_id_en[3], id_ex_en[3], ex_mem_en[3], mem_wb_en[3];
  logic       if_id_bubble[3], id_ex_bubble[3];
  logic [1:0] fwd1[3], fwd2[3];
  logic [15:0] sc_a, sc_b;
  logic [1:0]  sc_c;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYC(1), .FWD_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_redirect(id_redirect), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_we(ex_we),
    .mem_we(mem_we), .wb_we(wb_we), .ex_load(ex_load), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
    .id_ex_en(id_ex_en[0]), .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
    .if_id_bubble(if_id_bubble[0]), .id_ex_bubble(id_ex_bubble[0]), .fwd_src1(fwd1[0]),
    .fwd_src2(fwd2[0]), .stall_cycles(sc_a)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYC(3), .FWD_EN(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_redirect(id_redirect), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_we(ex_we),
    .mem_we(mem_we), .wb_we(wb_we), .ex_load(ex_load), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
    .id_ex_en(id_ex_en[1]), .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
    .if_id_bubble(if_id_bubble[1]), .id_ex_bubble(id_ex_bubble[1]), .fwd_src1(fwd1[1]),
    .fwd_src2(fwd2[1]), .stall_cycles(sc_b)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYC(1), .FWD_EN(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_redirect(id_redirect), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_we(ex_we),
    .mem_we(mem_we), .wb_we(wb_we), .ex_load(ex_load), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en[2]), .if_id_en(if_id_en[2]),
    .id_ex_en(id_ex_en[2]), .ex_mem_en(ex_mem_en[2]), .mem_wb_en(mem_wb_en[2]),
    .if_id_bubble(if_id_bubble[2]), .id_ex_bubble(id_ex_bubble[2]), .fwd_src1(fwd1[2]),
    .fwd_src2(fwd2[2]), .stall_cycles(sc_c)
  );

  // Configuration of each instance and the reference model's state.
  int luc[3]  = '{1, 3, 1};
  int fen[3]  = '{1, 1, 0};
  int cmax[3] = '{65535, 65535, 3};
  int bub[3];   // load-use bubbles still owed after the current one
  int cnt[3];   // expected stall_cycles
  bit e_pc[3];  // expected pc_en this cycle, kept for the counter update
  int nchk = 0;
  int nerr = 0;
  int nb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Does the ID instruction read the register this producer writes?
  function automatic bit reads(input logic [4:0] rd, input logic we);
    return we && (rd != 0) && ((id_use1 && id_rs1 == rd) || (id_use2 && id_rs2 == rd));
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic used);
    if (!used || rs == 0) return 2'b00;
    if (ex_we && ex_rd == rs && !ex_load) return 2'b01;
    if (mem_we && mem_rd == rs) return 2'b10;
    if (wb_we && wb_rd == rs) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit hazard(input int k);
    if (fen[k] != 0) return (bub[k] > 0) || (ex_load && reads(ex_rd, ex_we));
    return reads(ex_rd, ex_we) || reads(mem_rd, mem_we) || reads(wb_rd, wb_we);
  endfunction

  function automatic logic [31:0] sc_of(input int k);
    if (k == 0) return 32'(sc_a);
    if (k == 1) return 32'(sc_b);
    return 32'(sc_c);
  endfunction

  // Compare every output of every instance against the model, just before the edge.
  task automatic eval(input string tag);
    logic [1:0] f1, f2;
    bit pc, ifid, back, ifb, idb;
    #1;
    for (int k = 0; k < 3; k++) begin
      f1 = 2'b00; f2 = 2'b00; pc = 1; ifid = 1; back = 1; ifb = 0; idb = 0;
      if (!rst) begin
        if (fen[k] != 0) begin
          f1 = fwd_ref(id_rs1, id_use1);
          f2 = fwd_ref(id_rs2, id_use2);
        end
        if (dmem_req && !dmem_ready) begin
          pc = 0; ifid = 0; back = 0;
        end else if (hazard(k)) begin
          pc = 0; ifid = 0; idb = 1;
        end else begin
          pc  = imem_ready || id_redirect;
          ifb = !imem_ready || id_redirect;
        end
      end
      e_pc[k] = pc;
      check($sformatf("%s[%0d].pc_en", tag, k), 32'(pc_en[k]), 32'(pc));
      check($sformatf("%s[%0d].if_id_en", tag, k), 32'(if_id_en[k]), 32'(ifid));
      check($sformatf("%s[%0d].id_ex_en", tag, k), 32'(id_ex_en[k]), 32'(back));
      check($sformatf("%s[%0d].ex_mem_en", tag, k), 32'(ex_mem_en[k]), 32'(back));
      check($sformatf("%s[%0d].mem_wb_en", tag, k), 32'(mem_wb_en[k]), 32'(back));
      check($sformatf("%s[%0d].if_id_bubble", tag, k), 32'(if_id_bubble[k]), 32'(ifb));
      check($sformatf("%s[%0d].id_ex_bubble", tag, k), 32'(id_ex_bubble[k]), 32'(idb));
      check($sformatf("%s[%0d].fwd_src1", tag, k), 32'(fwd1[k]), 32'(f1));
      check($sformatf("%s[%0d].fwd_src2", tag, k), 32'(fwd2[k]), 32'(f2));
      check($sformatf("%s[%0d].stall_cycles", tag, k), sc_of(k), 32'(cnt[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        bub[k] = 0;
        cnt[k] = 0;
      end else begin
        if (!(dmem_req && !dmem_ready) && fen[k] != 0 && hazard(k))
          bub[k] = (bub[k] > 0) ? bub[k] - 1 : luc[k] - 1;
        if (!e_pc[k] && cnt[k] < cmax[k]) cnt[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0; id_redirect = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic load_in_ex();
    idle();
    ex_rd = 5; ex_we = 1; ex_load = 1;
    id_rs1 = 5; id_use1 = 1; id_rs2 = 1; id_use2 = 1;
  endtask

  task automatic load_in_mem();
    ex_rd = 0; ex_we = 0; ex_load = 0;
    mem_rd = 5; mem_we = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin bub[k] = 0; cnt[k] = 0; end
    @(negedge clk);
    eval("reset");
    check("reset.stall_cycles", 32'(sc_a), 32'd0);
    check("reset.pc_en", 32'(pc_en[0]), 32'd1);
    tick();
    rst = 0;
    eval("idle");
    tick();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    load_in_ex();
    eval("lu_detect");
    check("lu1.pc_en", 32'(pc_en[0]), 32'd0);
    check("lu1.id_ex_bubble", 32'(id_ex_bubble[0]), 32'd1);
    tick();
    load_in_mem();
    eval("lu_after1");
    check("lu1.released", 32'(pc_en[0]), 32'd1);
    check("lu1.fwd_src1", 32'(fwd1[0]), 32'b10);
    check("lu3.stall2", 32'(pc_en[1]), 32'd0);
    tick();
    eval("lu_after2");
    check("lu3.stall3", 32'(pc_en[1]), 32'd0);
    tick();
    eval("lu_after3");
    check("lu3.released", 32'(pc_en[1]), 32'd1);
    check("lu3.stall_cycles", 32'(sc_b), 32'd3);
    check("lu1.stall_cycles", 32'(sc_a), 32'd1);
    check("il.sat_cnt", 32'(sc_c), 32'd3);
    tick();
    idle();
    eval("idle2");
    check("il.sat_hold", 32'(sc_c), 32'd3);
    tick();

    // Data-memory wait in the middle of a 3-cycle load-use stall.
    nb = 0;
    load_in_ex();
    eval("dw_detect");
    nb += int'(id_ex_bubble[1]);
    tick();
    load_in_mem();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      eval("dw_wait");
      check("dw.pc_en", 32'(pc_en[1]), 32'd0);
      check("dw.ex_mem_en", 32'(ex_mem_en[1]), 32'd0);
      nb += int'(id_ex_bubble[1]);
      tick();
    end
    dmem_ready = 1;
    eval("dw_release");
    nb += int'(id_ex_bubble[1]);
    tick();
    idle();
    eval("dw_tail1");
    nb += int'(id_ex_bubble[1]);
    tick();
    eval("dw_tail2");
    nb += int'(id_ex_bubble[1]);
    check("dw.bubble_count", 32'(nb), 32'd3);
    tick();

    // Forward priority with the same register in every stage.
    idle();
    ex_rd = 7; mem_rd = 7; wb_rd = 7; ex_we = 1; mem_we = 1; wb_we = 1;
    id_rs2 = 7; id_use2 = 1;
    eval("fwd_ex");
    check("fwd.ex", 32'(fwd2[0]), 32'b01);
    tick();
    ex_rd = 0;
    eval("fwd_mem");
    check("fwd.mem", 32'(fwd2[0]), 32'b10);
    tick();
    mem_we = 0;
    eval("fwd_wb");
    check("fwd.wb", 32'(fwd2[0]), 32'b11);
    tick();

    // Redirect during an instruction-fetch miss, then a plain miss.
    idle();
    imem_ready = 0; id_redirect = 1;
    eval("redir_miss");
    check("redir.pc_en", 32'(pc_en[0]), 32'd1);
    check("redir.if_id_bubble", 32'(if_id_bubble[0]), 32'd1);
    tick();
    id_redirect = 0;
    eval("miss");
    check("miss.pc_en", 32'(pc_en[0]), 32'd0);
    check("miss.if_id_bubble", 32'(if_id_bubble[0]), 32'd1);
    tick();

    // Interlock-only instance against a producer sitting in WB.
    idle();
    wb_rd = 3; wb_we = 1; id_rs1 = 3; id_use1 = 1;
    eval("il_wb");
    check("il.stall", 32'(pc_en[2]), 32'd0);
    check("il.fwd_src1", 32'(fwd1[2]), 32'd0);
    check("fw.fwd_src1", 32'(fwd1[0]), 32'b11);
    tick();
    wb_we = 0;
    eval("il_free");
    check("il.released", 32'(pc_en[2]), 32'd1);
    tick();

    // Reset while frozen in D_WAIT.
    idle();
    dmem_req = 1; dmem_ready = 0;
    eval("rst_dw_enter");
    tick();
    eval("rst_dw_hold");
    rst = 1;
    eval("rst_dw_assert");
    tick();
    rst = 0;
    idle();
    eval("rst_dw_after");
    check("rst_dw.pc_en", 32'(pc_en[1]), 32'd1);
    check("rst_dw.stall_cycles", 32'(sc_b), 32'd0);
    tick();

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      wb_rd       = 5'($urandom_range(0, 3));
      id_use1     = 1'($urandom);
      id_use2     = 1'($urandom);
      ex_we       = 1'($urandom);
      mem_we      = 1'($urandom);
      wb_we       = 1'($urandom);
      ex_load     = ($urandom_range(0, 3) == 0);
      id_redirect = ($urandom_range(0, 3) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready  = 1'($urandom);
      eval("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
